id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//   Parametrised decode stage: decodes the IF/ID instruction, owns the register file, selects the ALU
//   operands with 2-source forwarding, and holds the result in an internal ID/EX register with a
//   valid/ready handshake. Sits between the IF/ID register and the EX unit; CPU_control drives the
//   control inputs from 'opcode'.
// PARAMETERS
//   DATA_W    32            datapath / register width
//   NREG      32            register count; RA_W = $clog2(NREG)
//   SP_REG    29            stack pointer index
//   EPC_REG   30            exception PC index (jreg through it flags interrupt return)
//   SP_RESET  32'h00000FFF  SP value after reset
//   SP_LIMIT  32'h00000800  lowest legal SP (STACK_CHECK_EN only)
// PORTS
//   clk            in   1       clock, all state on posedge
//   rst_n          in   1       asynchronous reset, active low
//   in_valid       in   1       IF/ID holds a valid instruction
//   in_ready       out  1       stage accepts this cycle
//   instr, pc      in   32,32   instruction; PC+1 of the instruction
//   opcode         out  6       instr[31:26], combinational
//   call,ret,push,pop,branch,jreg,reg2_sel,sext_sel  in 1 each   decoded control
//   alu_src        in   2       operand mode
//   rd_en1, rd_en2 in   1       read-port enables
//   data_hazard    in   1       load-use stall request
//   flush          in   1       kill stage content (taken branch / interrupt)
//   wb_we, wb_reg, wb_data  in  1,RA_W,DATA_W   write-back port
//   fwd_sel1, fwd_sel2      in  2   00 regfile, 01 ex_fwd_data, 10 wb_data, 11 regfile
//   ex_fwd_data    in   DATA_W  EX/MEM result for forwarding
//   out_valid      out  1       ID/EX content valid
//   out_ready      in   1       EX consumes this cycle
//   ex_op1, ex_op2, ex_store_data  out  DATA_W  registered operands / store data
//   ex_dest, ex_rs1, ex_rs2        out  RA_W    registered dest and source indices
//   ex_jimm, ex_pc                 out  26,32   registered J immediate, PC
//   ex_intr_return                 out  1       registered jreg & (rs1 == EPC_REG)
//   stack_fault                    out  1       sticky stack fault (STACK_CHECK_EN)
// BEHAVIOUR
//   Decode: rd=instr[25:21], rs=instr[20:16], rt=instr[15:11], shamt=instr[10:6], imm16=[15:0], jimm=[25:0].
//   rs1 = SP_REG if call|ret|push|pop else rs; rs2 = rt if reg2_sel else rd; dest = SP_REG if call|ret|push else rd.
//   Regfile: write at posedge when wb_we; reg 0 always reads 0 and ignores writes. Same-cycle write to a
//     read address bypasses (read returns wb_data). Disabled port (rd_enX & ~data_hazard = 0) reads 0.
//   Operands: alu_src 00 {r1,r2}; 01 {branch?pc:r1, sext}; 10 {r1, SP-op?1:zero-ext shamt}; 11 {0,0}.
//     sext = sext_sel ? sign-ext jimm : sign-ext imm16. Forward mux replaces r1/r2 before the operand mux
//     except op2 constant 1 for SP ops; store_data = forwarded r2.
//   Handshake: in_ready = ~data_hazard & (~out_valid | out_ready); accept = in_valid & in_ready.
//     accept: all ex_* load, out_valid<=1; else if out_ready: out_valid<=0; else hold (ex_* stable).
//     flush: out_valid<=0 next edge, overrides accept; regfile write still occurs.
//   Latency: 1 cycle from accept to out_valid; back-to-back accepts at full rate when out_ready=1.
//   Reset (rst_n=0, async): out_valid=0, all ex_* =0, stack_fault=0, regs=0, reg[SP_REG]=SP_RESET;
//     reset mid-operation discards the ID/EX content. in_ready=0 while rst_n=0.
// CONFIGURATION
//   STACK_CHECK_EN defined: on accept of push|call with SP_before <= SP_LIMIT, or pop|ret with
//     SP_before == SP_RESET, stack_fault<=1 and stays 1 until reset; instruction still issues.
//   Not defined: stack_fault tied 0, no compare logic.
// TESTING
//   Reset, no traffic -> SP read via push gives ex_op1=32'h00000FFF, ex_op2=1, ex_dest=29, out_valid=1 next cycle.
//   ADD r3,r1,r2 with wb writing r1=5 same cycle, fwd_sel2=01 ex_fwd_data=7 -> ex_op1=5, ex_op2=7.
//   out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ex_* held; out_ready=1 -> next instr loads.
//   data_hazard=1 -> in_ready=0, out_valid drops after EX consumes; flush with accept -> out_valid=0.
//   jreg with rs=30 -> ex_intr_return=1; rs=31 -> 0; branch, imm16=16'hFFFE -> ex_op1=pc, ex_op2=32'hFFFFFFFE.
//   STACK_CHECK_EN: pop at SP=32'h00000FFF -> stack_fault=1 held; rst_n pulse -> 0; without macro stays 0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage with register file, 2-source forwarding and ID/EX valid/ready register
//
// Purpose : decodes the IF/ID instruction, reads the register file (with write-back bypass),
//           selects ALU operands after forwarding and holds them in the ID/EX register.
// Ports   : clk, rst_n                      clock, async active-low reset
//           in_valid/in_ready               upstream handshake
//           instr, pc, opcode               instruction word, PC+1, opcode (combinational)
//           call..sext_sel, alu_src,
//           rd_en1/2, data_hazard, flush    decoded control from CPU_control / hazard unit
//           wb_we, wb_reg, wb_data          register-file write-back port
//           fwd_sel1/2, ex_fwd_data         forwarding selects and EX/MEM result
//           out_valid/out_ready             downstream handshake
//           ex_*                            registered ID/EX content
//           stack_fault                     sticky stack over/underflow flag
// Config  : STACK_CHECK_EN enables the stack fault check; otherwise stack_fault is tied 0.
module id_stage_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                NREG     = 32,
    parameter int                SP_REG   = 29,
    parameter int                EPC_REG  = 30,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h00000FFF,
    parameter logic [DATA_W-1:0] SP_LIMIT = 32'h00000800,
    localparam int               RA_W     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [31:0]       pc,
    output logic [5:0]        opcode,
    input  logic              call,
    input  logic              ret,
    input  logic              push,
    input  logic              pop,
    input  logic              branch,
    input  logic              jreg,
    input  logic              reg2_sel,
    input  logic              sext_sel,
    input  logic [1:0]        alu_src,
    input  logic              rd_en1,
    input  logic              rd_en2,
    input  logic              data_hazard,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [RA_W-1:0]   wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [1:0]        fwd_sel1,
    input  logic [1:0]        fwd_sel2,
    input  logic [DATA_W-1:0] ex_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [RA_W-1:0]   ex_dest,
    output logic [RA_W-1:0]   ex_rs1,
    output logic [RA_W-1:0]   ex_rs2,
    output logic [25:0]       ex_jimm,
    output logic [31:0]       ex_pc,
    output logic              ex_intr_return,
    output logic              stack_fault
);

    logic [DATA_W-1:0] rf_q [NREG];

    logic              sp_op, en1, en2, accept;
    logic [RA_W-1:0]   rs1, rs2, dest;
    logic [DATA_W-1:0] r1, r2, f1, f2, sext, op1_d, op2_d;

    logic              valid_q;
    logic [DATA_W-1:0] op1_q, op2_q, sd_q;
    logic [RA_W-1:0]   dest_q, rs1_q, rs2_q;
    logic [25:0]       jimm_q;
    logic [31:0]       pc_q;
    logic              intr_q;

    assign opcode = instr[31:26];
    assign sp_op  = call | ret | push | pop;
    assign rs1    = sp_op ? RA_W'(SP_REG) : RA_W'(instr[20:16]);
    assign rs2    = reg2_sel ? RA_W'(instr[15:11]) : RA_W'(instr[25:21]);
    assign dest   = (call | ret | push) ? RA_W'(SP_REG) : RA_W'(instr[25:21]);

    // A stalled read port returns 0 so a held-off instruction never sees stale data.
    assign en1 = rd_en1 & ~data_hazard;
    assign en2 = rd_en2 & ~data_hazard;

    assign in_ready = rst_n & ~data_hazard & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= (i == SP_REG) ? SP_RESET : '0;
            end
        end else if (wb_we && (wb_reg != '0)) begin
            rf_q[wb_reg] <= wb_data;
        end
    end

    // Same-cycle write-back bypass; register 0 is hardwired to zero.
    always_comb begin
        r1 = '0;
        if (en1 && (rs1 != '0)) r1 = (wb_we && (wb_reg == rs1)) ? wb_data : rf_q[rs1];
    end

    always_comb begin
        r2 = '0;
        if (en2 && (rs2 != '0)) r2 = (wb_we && (wb_reg == rs2)) ? wb_data : rf_q[rs2];
    end

    always_comb begin
        f1 = r1;
        f2 = r2;
        if (fwd_sel1 == 2'b01) f1 = ex_fwd_data;
        if (fwd_sel1 == 2'b10) f1 = wb_data;
        if (fwd_sel2 == 2'b01) f2 = ex_fwd_data;
        if (fwd_sel2 == 2'b10) f2 = wb_data;
    end

    assign sext = sext_sel ? {{(DATA_W-26){instr[25]}}, instr[25:0]}
                           : {{(DATA_W-16){instr[15]}}, instr[15:0]};

    always_comb begin
        op1_d = '0;
        op2_d = '0;
        case (alu_src)
            2'b00: begin
                op1_d = f1;
                op2_d = f2;
            end
            2'b01: begin
                op1_d = branch ? DATA_W'(pc) : f1;
                op2_d = sext;
            end
            2'b10: begin
                op1_d = f1;
                op2_d = sp_op ? {{(DATA_W-1){1'b0}}, 1'b1} : {{(DATA_W-5){1'b0}}, instr[10:6]};
            end
            default: begin
                op1_d = '0;
                op2_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            sd_q    <= '0;
            dest_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            jimm_q  <= '0;
            pc_q    <= '0;
            intr_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sd_q    <= f2;
            dest_q  <= dest;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            jimm_q  <= instr[25:0];
            pc_q    <= pc;
            intr_q  <= jreg & (rs1 == RA_W'(EPC_REG));
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid      = valid_q;
    assign ex_op1         = op1_q;
    assign ex_op2         = op2_q;
    assign ex_store_data  = sd_q;
    assign ex_dest        = dest_q;
    assign ex_rs1         = rs1_q;
    assign ex_rs2         = rs2_q;
    assign ex_jimm        = jimm_q;
    assign ex_pc          = pc_q;
    assign ex_intr_return = intr_q;

`ifdef STACK_CHECK_EN
    logic              fault_q;
    logic [DATA_W-1:0] sp_now;

    // SP as the instruction sees it, including a same-cycle write-back.
    assign sp_now = (wb_we && (wb_reg == RA_W'(SP_REG))) ? wb_data : rf_q[SP_REG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (accept && (((push | call) && (sp_now <= SP_LIMIT)) ||
                                ((pop | ret) && (sp_now == SP_RESET)))) begin
            fault_q <= 1'b1;
        end
    end

    assign stack_fault = fault_q;
`else
    assign stack_fault = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard testbench for id_stage_pipe
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] instr, pc;
    logic [5:0]  opcode;
    logic        call, ret, push, pop, branch, jreg, reg2_sel, sext_sel;
    logic [1:0]  alu_src;
    logic        rd_en1, rd_en2, data_hazard, flush;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [31:0] ex_fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] ex_op1, ex_op2, ex_store_data;
    logic [4:0]  ex_dest, ex_rs1, ex_rs2;
    logic [25:0] ex_jimm;
    logic [31:0] ex_pc;
    logic        ex_intr_return, stack_fault;

    id_stage_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .opcode(opcode),
        .call(call), .ret(ret), .push(push), .pop(pop), .branch(branch), .jreg(jreg),
        .reg2_sel(reg2_sel), .sext_sel(sext_sel), .alu_src(alu_src),
        .rd_en1(rd_en1), .rd_en2(rd_en2), .data_hazard(data_hazard), .flush(flush),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .ex_fwd_data(ex_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_jimm(ex_jimm), .ex_pc(ex_pc), .ex_intr_return(ex_intr_return),
        .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1, op2, sd;
        logic [4:0]  dest, rs1, rs2;
        logic [25:0] jimm;
        logic [31:0] pc;
        logic        intr;
    } exp_t;

    exp_t exp_cur;
    exp_t sb[$];
    bit   mv;
    int   n_cmp = 0;
    int   n_fail = 0;
`ifdef STACK_CHECK_EN
    localparam logic SF_EXP = 1'b1;
`else
    localparam logic SF_EXP = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] lo);
        return {op, rd, rs, lo};
    endfunction

    task automatic setexp(input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] sd,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [25:0] j, input logic [31:0] p, input logic ir);
        exp_cur.op1 = o1; exp_cur.op2 = o2; exp_cur.sd = sd;
        exp_cur.dest = d; exp_cur.rs1 = s1; exp_cur.rs2 = s2;
        exp_cur.jimm = j; exp_cur.pc = p; exp_cur.intr = ir;
    endtask

    task automatic idle();
        in_valid = 0; call = 0; ret = 0; push = 0; pop = 0; branch = 0; jreg = 0;
        reg2_sel = 0; sext_sel = 0; alu_src = 2'b00; rd_en1 = 0; rd_en2 = 0;
        data_hazard = 0; flush = 0; wb_we = 0; wb_reg = 0; wb_data = 0;
        fwd_sel1 = 2'b00; fwd_sel2 = 2'b00; ex_fwd_data = 0; out_ready = 1;
        instr = 0; pc = 0;
    endtask

    // One clock: check handshake against the model, then push the expected
    // ID/EX content if the instruction is accepted and not flushed.
    task automatic cyc();
        logic ir_exp;
        ir_exp = !data_hazard && (!mv || out_ready);
        @(negedge clk);
        chk("in_ready", {31'b0, in_ready}, {31'b0, ir_exp});
        chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
        @(posedge clk);
        if (flush) mv = 0;
        else if (in_valid && ir_exp) begin
            mv = 1;
            sb.push_back(exp_cur);
        end else if (out_ready) mv = 0;
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected empty scoreboard at %0t", $time);
            end else begin
                e = sb[0];
                chk("ex_op1", ex_op1, e.op1);
                chk("ex_op2", ex_op2, e.op2);
                chk("ex_store_data", ex_store_data, e.sd);
                chk("ex_dest", {27'b0, ex_dest}, {27'b0, e.dest});
                chk("ex_rs1", {27'b0, ex_rs1}, {27'b0, e.rs1});
                chk("ex_rs2", {27'b0, ex_rs2}, {27'b0, e.rs2});
                chk("ex_jimm", {6'b0, ex_jimm}, {6'b0, e.jimm});
                chk("ex_pc", ex_pc, e.pc);
                chk("ex_intr_return", {31'b0, ex_intr_return}, {31'b0, e.intr});
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        idle();
        rst_n = 0;
        in_valid = 1;
        mv = 0;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ex_op1", ex_op1, 32'd0);
        chk("rst_ex_dest", {27'b0, ex_dest}, 32'd0);
        chk("rst_stack_fault", {31'b0, stack_fault}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        idle();

        // push reads SP reset value, op2 = 1, dest = SP
        idle(); in_valid = 1; push = 1; rd_en1 = 1; alu_src = 2'b10; pc = 32'h10;
        setexp(32'hFFF, 32'h1, 0, 29, 29, 0, 26'h0, 32'h10, 0); cyc();

        // ADD r3,r1,r2: wb r1=5 bypass, op2 forwarded from EX
        idle(); in_valid = 1; instr = mk(6'h0, 3, 1, 16'h1000); reg2_sel = 1;
        rd_en1 = 1; rd_en2 = 1; wb_we = 1; wb_reg = 1; wb_data = 5;
        fwd_sel2 = 2'b01; ex_fwd_data = 7; pc = 32'h11;
        setexp(5, 7, 7, 3, 1, 2, 26'h611000, 32'h11, 0); cyc();

        // fwd_sel1=11 selects regfile; r2=9 bypassed on port 2
        idle(); in_valid = 1; instr = mk(6'h0, 4, 1, 16'h1000); reg2_sel = 1;
        rd_en1 = 1; rd_en2 = 1; wb_we = 1; wb_reg = 2; wb_data = 9;
        fwd_sel1 = 2'b11; pc = 32'h12;
        setexp(5, 9, 9, 4, 1, 2, 26'h811000, 32'h12, 0); cyc();

        // r0 reads zero even with a same-cycle write to r0
        idle(); in_valid = 1; instr = mk(6'h0, 0, 0, 16'h0);
        rd_en1 = 1; rd_en2 = 1; wb_we = 1; wb_reg = 0; wb_data = 32'hDEAD; pc = 32'h13;
        setexp(0, 0, 0, 0, 0, 0, 26'h0, 32'h13, 0); cyc();

        // disabled port 2 reads zero
        idle(); in_valid = 1; instr = mk(6'h0, 1, 2, 16'h0); rd_en1 = 1; pc = 32'h14;
        setexp(9, 0, 0, 1, 2, 1, 26'h220000, 32'h14, 0); cyc();

        // branch: op1 = pc, op2 = sign-extended imm16
        idle(); in_valid = 1; instr = mk(6'h04, 0, 1, 16'hFFFE); branch = 1;
        alu_src = 2'b01; rd_en1 = 1; rd_en2 = 1; pc = 32'h20;
        setexp(32'h20, 32'hFFFFFFFE, 0, 0, 1, 0, 26'h001FFFE, 32'h20, 0); cyc();
        chk("opcode", {26'b0, opcode}, 32'h4);

        // sign-extended J immediate
        idle(); in_valid = 1; instr = {6'h02, 26'h2000001}; sext_sel = 1;
        alu_src = 2'b01; rd_en1 = 1; rd_en2 = 1; pc = 32'h21;
        setexp(0, 32'hFE000001, 0, 16, 0, 16, 26'h2000001, 32'h21, 0); cyc();

        // zero-extended shamt
        idle(); in_valid = 1; instr = mk(6'h0, 5, 2, 16'h0340); alu_src = 2'b10;
        rd_en1 = 1; rd_en2 = 1; pc = 32'h22;
        setexp(9, 13, 0, 5, 2, 5, 26'hA20340, 32'h22, 0); cyc();

        // alu_src 11 zeroes operands, store data still forwarded r2
        idle(); in_valid = 1; instr = mk(6'h0, 1, 2, 16'h0); alu_src = 2'b11;
        rd_en1 = 1; rd_en2 = 1; pc = 32'h23;
        setexp(0, 0, 5, 1, 2, 1, 26'h220000, 32'h23, 0); cyc();

        // jreg through EPC vs r31
        idle(); in_valid = 1; instr = mk(6'h0, 0, 30, 16'h0); jreg = 1;
        rd_en1 = 1; rd_en2 = 1; pc = 32'h24;
        setexp(0, 0, 0, 0, 30, 0, 26'h1E0000, 32'h24, 1); cyc();
        idle(); in_valid = 1; instr = mk(6'h0, 0, 31, 16'h0); jreg = 1;
        rd_en1 = 1; rd_en2 = 1; pc = 32'h25;
        setexp(0, 0, 0, 0, 31, 0, 26'h1F0000, 32'h25, 0); cyc();

        // backpressure: A accepted, B stalled 3 cycles, then loads
        idle(); in_valid = 1; instr = mk(6'h0, 3, 1, 16'h1000); reg2_sel = 1;
        rd_en1 = 1; rd_en2 = 1; pc = 32'h30;
        setexp(5, 9, 9, 3, 1, 2, 26'h611000, 32'h30, 0); cyc();
        idle(); in_valid = 1; instr = mk(6'h0, 4, 2, 16'h0800); reg2_sel = 1;
        rd_en1 = 1; rd_en2 = 1; pc = 32'h31; out_ready = 0;
        setexp(9, 5, 5, 4, 2, 1, 26'h820800, 32'h31, 0);
        for (int i = 0; i < 3; i++) cyc();
        out_ready = 1; cyc();

        // flush with accept: nothing issues, but r6 write happens
        idle(); in_valid = 1; flush = 1; instr = mk(6'h0, 9, 9, 16'h0); rd_en1 = 1;
        wb_we = 1; wb_reg = 6; wb_data = 32'h66; pc = 32'h40; cyc();
        idle(); in_valid = 1; instr = mk(6'h0, 0, 6, 16'h0); rd_en1 = 1; rd_en2 = 1; pc = 32'h41;
        setexp(32'h66, 0, 0, 0, 6, 0, 26'h060000, 32'h41, 0); cyc();

        // load-use stall: in_ready low, out_valid drops after consume
        idle(); in_valid = 1; data_hazard = 1; rd_en1 = 1; instr = mk(6'h0, 1, 1, 16'h0);
        cyc(); cyc();

        // pop at SP reset value; held with out_ready low
        idle(); in_valid = 1; pop = 1; alu_src = 2'b10; rd_en1 = 1; rd_en2 = 1;
        instr = mk(6'h0, 7, 0, 16'h0); pc = 32'h50;
        setexp(32'hFFF, 1, 0, 7, 29, 7, 26'hE00000, 32'h50, 0); cyc();
        idle(); out_ready = 0; cyc();
        chk("stack_fault_pop", {31'b0, stack_fault}, {31'b0, SF_EXP});
        cyc();
        chk("stack_fault_held", {31'b0, stack_fault}, {31'b0, SF_EXP});

        // reset mid-operation discards ID/EX content
        rst_n = 0; in_valid = 1; out_ready = 1;
        sb.delete(); mv = 0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_ex_op1", ex_op1, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_stack_fault", {31'b0, stack_fault}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // SP restored after reset; push at SP > limit raises no fault
        idle(); in_valid = 1; push = 1; rd_en1 = 1; alu_src = 2'b10; pc = 32'h60;
        setexp(32'hFFF, 32'h1, 0, 29, 29, 0, 26'h0, 32'h60, 0); cyc();
        idle(); cyc(); cyc();
        chk("stack_fault_final", {31'b0, stack_fault}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
